stepper_phase_decoder: RTL
==========================

# stepper_phase_decoder

Observes the six phase/inhibit lines (A, B, C, D, INH1, INH2) driven toward the stepper bridge by the motor controller. Reconstructs the motor's position in half-step units, the direction of movement, and the step mode. Sits on the bridge side of the interface as a position monitor and feedback source. Detects glitches, skipped steps and illegal phase patterns.

## Interface
Parameters:
- FILTER, 2, consecutive synchronized cycles a new pattern must hold before acceptance (>=1)
- POS_W, 16, width of position counter

Ports:
- CLK  in  1  system clock, all logic on rising edge
- RESET  in  1  asynchronous, active-low reset
- A, B, C, D  in  1 each  bridge phase lines, asynchronous to CLK
- INH1, INH2  in  1 each  bridge inhibit lines (active-low inhibit), asynchronous to CLK
- CLR_POS  in  1  synchronous clear of POS
- CLR_ERR  in  1  synchronous clear of ERR
- POS  out  POS_W  signed two's-complement position in half-steps
- DIR  out  1  direction of last accepted move (1 = up)
- STEP  out  1  one-cycle pulse per accepted move
- FULL  out  1  last accepted move was a full step (±2)
- VALID  out  1  reference phase held (tracking)
- ERR  out  1  sticky fault flag

## Operation
- Pattern coding {A,B,C,D,INH1,INH2} maps to phase index p:
  - 010111 → p=0
  - 000101 → p=1
  - 100111 → p=2
  - 100010 → p=3
  - 101011 → p=4
  - 001001 → p=5
  - 011011 → p=6
  - 010010 → p=7
- Idle pattern: 000011. All other 55 codes are illegal.
- Input path: 2-FF synchronizer on all six lines, then stability filter. A pattern is accepted once the synchronized value has been identical for FILTER consecutive cycles. Accepted pattern is processed once per change.
- FSM states:
  - IDLE (no reference phase):
    - legal phase accepted → reference=p, VALID=1, go TRACK. No STEP, POS unchanged.
    - idle pattern accepted → stay.
    - illegal pattern accepted → ERR=1, stay.
  - TRACK: on accepted legal phase p', delta=(p'-ref) mod 8:
    - 0 → nothing.
    - 1 → POS+1, DIR=1, FULL=0, STEP.
    - 2 → POS+2, DIR=1, FULL=1, STEP.
    - 7 → POS-1, DIR=0, FULL=0, STEP.
    - 6 → POS-2, DIR=0, FULL=1, STEP.
    - 3, 4, 5 → skipped-step fault: ERR=1, no STEP, POS/DIR/FULL held.
    - In every case ref=p'.
  - TRACK, idle pattern accepted → VALID=0, go IDLE, no error.
  - TRACK, illegal pattern accepted → ERR=1, VALID=0, go IDLE.
- POS arithmetic is modulo 2^POS_W: 0x7FFF+1 → 0x8000 and 0x0000-1 → 0xFFFF (POS_W=16). No saturation.
- CLR_POS sets POS=0 and has priority over a same-cycle move. STEP, DIR and FULL still update.
- ERR set and CLR_ERR in the same cycle: set wins, ERR stays 1.
- Reset values:
  - POS=0, DIR=0, STEP=0, FULL=0, VALID=0, ERR=0.
  - FSM=IDLE, ref=0.
  - Synchronizer and filter registers preset to the idle pattern, so release from reset causes no spurious fault.
- RESET asserted mid-move discards the pending filtered pattern and returns all state to reset values immediately.

## Timing
- Latency: the pin change is first sampled at edge k. The pattern is accepted at edge k+1+FILTER. POS, DIR, FULL, VALID, ERR and STEP update at that edge, i.e. visible after edge k+1+FILTER (3 cycles at FILTER=2).
- Glitches shorter than FILTER synchronized cycles are ignored with no output effect.
- STEP is exactly one cycle high per accepted move and never high on consecutive cycles unless the accepted pattern changed on consecutive cycles. That is impossible for FILTER≥2.
- Minimum hold time of each phase for correct tracking: FILTER+1 cycles.
- CLR_POS and CLR_ERR act at the next edge with no synchronization delay. They are assumed synchronous to CLK.

## Test plan
- Reset, pins held at 000011 for 20 cycles → VALID=0, POS=0, ERR=0, no STEP.
- Half-step up: p=0,1,…,7,0, each held 5 cycles → VALID=1 after p=0 with no STEP, then 8 STEP pulses, POS=8, DIR=1, FULL=0, ERR=0.
- Full-step down from p=0: p=6,4,2,0, each held 5 cycles → 4 STEP pulses, POS=0xFFF8 (-8), DIR=0, FULL=1.
- Glitch: tracking at p=0, p=1 applied for 1 cycle then back to p=0 → no STEP, POS unchanged, ERR=0.
- Skip and relock:
  - p=0→p=4 → ERR=1, no STEP, POS held.
  - Then p=5 → STEP, POS+1.
  - CLR_ERR pulse → ERR=0.
  - Illegal 110011 → ERR=1, VALID=0.
  - Next legal phase → VALID=1 with no STEP.
- Wrap and priority:
  - Preset POS to 0x7FFF via 32767 up-steps (or forced in bench), then one up-step → POS=0x8000.
  - CLR_POS coincident with an accepted move → POS=0, STEP pulses.

Source files
------------

// File: rtl/stepper_phase_decoder.sv
// Position monitor for a stepper bridge: synchronizes and debounces the six
// phase/inhibit lines, then tracks half-step position, direction and faults.
module stepper_phase_decoder #(
   parameter int FILTER = 2,
   parameter int POS_W  = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             A,
   input  logic             B,
   input  logic             C,
   input  logic             D,
   input  logic             INH1,
   input  logic             INH2,
   input  logic             CLR_POS,
   input  logic             CLR_ERR,
   output logic [POS_W-1:0] POS,
   output logic             DIR,
   output logic             STEP,
   output logic             FULL,
   output logic             VALID,
   output logic             ERR
);

   localparam logic [5:0]    IDLE_PAT = 6'b000011;
   localparam int            CW       = $clog2(FILTER + 1);
   localparam logic [CW-1:0] CNT_SAT  = CW'(FILTER);
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [POS_W-1:0] ONE   = POS_W'(1);
   localparam logic [POS_W-1:0] TWO   = POS_W'(2);

   typedef enum logic {S_IDLE, S_TRACK} state_t;

   state_t          state_q, state_d;
   logic [2:0]      ref_q, ref_d;
   logic [5:0]      pins, sync1, sync2, cand, acc;
   logic [CW-1:0]   cnt;
   logic            same, accept, new_evt;
   logic            legal, err_set;
   logic [2:0]      idx, delta;
   logic [POS_W-1:0] pos_d;
   logic            dir_d, full_d, step_d, err_d;

   function automatic logic [3:0] decode(input logic [5:0] pat);
      case (pat)
         6'b010111: decode = {1'b1, 3'd0};
         6'b000101: decode = {1'b1, 3'd1};
         6'b100111: decode = {1'b1, 3'd2};
         6'b100010: decode = {1'b1, 3'd3};
         6'b101011: decode = {1'b1, 3'd4};
         6'b001001: decode = {1'b1, 3'd5};
         6'b011011: decode = {1'b1, 3'd6};
         6'b010010: decode = {1'b1, 3'd7};
         default:   decode = 4'b0000;
      endcase
   endfunction

   assign pins = {A, B, C, D, INH1, INH2};

   // Presetting to the idle pattern keeps reset release from looking like a pin change.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         sync1 <= IDLE_PAT;
         sync2 <= IDLE_PAT;
         cand  <= IDLE_PAT;
         cnt   <= CNT_SAT;
         acc   <= IDLE_PAT;
      end else begin
         // NOTE: non-blocking so sync2 takes the old sync1, giving a true two-stage chain.
         sync1 <= pins;
         sync2 <= sync1;
         if (!same) begin
            cand <= sync2;
            cnt  <= CNT_ONE;
         end else if (cnt != CNT_SAT) begin
            cnt <= cnt + CNT_ONE;
         end
         if (new_evt) acc <= sync2;
      end
   end

   assign same    = (sync2 == cand);
   assign accept  = same ? (cnt == CNT_LAST) : (FILTER == 1);
   assign new_evt = accept && (sync2 != acc);
   assign VALID   = (state_q == S_TRACK);

   always_comb begin
      // NOTE: every output of this block is defaulted first so no latch can be inferred.
      state_d = state_q;
      ref_d   = ref_q;
      pos_d   = POS;
      dir_d   = DIR;
      full_d  = FULL;
      step_d  = 1'b0;
      err_set = 1'b0;
      {legal, idx} = decode(sync2);
      delta   = idx - ref_q;
      if (new_evt) begin
         case (state_q)
            S_IDLE: begin
               if (legal) begin
                  ref_d   = idx;
                  state_d = S_TRACK;
               end else if (sync2 != IDLE_PAT) begin
                  err_set = 1'b1;
               end
            end
            S_TRACK: begin
               if (legal) begin
                  ref_d = idx;
                  case (delta)
                     3'd0: ;
                     3'd1: begin pos_d = POS + ONE; dir_d = 1'b1; full_d = 1'b0; step_d = 1'b1; end
                     3'd2: begin pos_d = POS + TWO; dir_d = 1'b1; full_d = 1'b1; step_d = 1'b1; end
                     3'd7: begin pos_d = POS - ONE; dir_d = 1'b0; full_d = 1'b0; step_d = 1'b1; end
                     3'd6: begin pos_d = POS - TWO; dir_d = 1'b0; full_d = 1'b1; step_d = 1'b1; end
                     default: err_set = 1'b1;
                  endcase
               end else begin
                  state_d = S_IDLE;
                  err_set = (sync2 != IDLE_PAT);
               end
            end
         endcase
      end
      if (CLR_POS) pos_d = '0;
      // A fault raised in the same cycle as a clear request must survive.
      err_d = err_set | (ERR & ~CLR_ERR);
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= S_IDLE;
         ref_q   <= 3'd0;
         POS     <= '0;
         DIR     <= 1'b0;
         FULL    <= 1'b0;
         STEP    <= 1'b0;
         ERR     <= 1'b0;
      end else begin
         state_q <= state_d;
         ref_q   <= ref_d;
         POS     <= pos_d;
         DIR     <= dir_d;
         FULL    <= full_d;
         STEP    <= step_d;
         ERR     <= err_d;
      end
   end

endmodule
